// File: rtl/pipeline_ctl_unit_pkg.sv
// Shared definitions for the ID/EX pipeline control unit:
// opcode constants, ALU operation codes and FSM state encoding.
package pipeline_ctl_unit_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_NOP   = 7'b0000000;

  localparam logic [6:0] F7_BASE  = 7'h00;
  localparam logic [6:0] F7_ALT   = 7'h20;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ADD_64  = 3'd1,
    SUB_64  = 3'd2,
    BIT_AND = 3'd3,
    BIT_OR  = 3'd4,
    BIT_XOR = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/pipeline_ctl_unit_decode.sv
// Combinational instruction decode (module pipeline_ctl_decode).
// Inputs : opcode, funct3, funct7.
// Outputs: unregistered control bundle, alu_operation, is_halt (opcode
//          outside the supported set) and illegal (unsupported R/I funct).
module pipeline_ctl_decode
  import pipeline_ctl_unit_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic                is_halt,
  output logic                illegal
);

  always_comb begin
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    alu_operation = ALU_OP_W'(ALU_NOP);
    is_halt       = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        if (funct3 == 3'b000 && funct7 == F7_BASE)      alu_operation = ALU_OP_W'(ADD_64);
        else if (funct3 == 3'b000 && funct7 == F7_ALT)  alu_operation = ALU_OP_W'(SUB_64);
        else if (funct3 == 3'b111 && funct7 == F7_BASE) alu_operation = ALU_OP_W'(BIT_AND);
        else if (funct3 == 3'b110 && funct7 == F7_BASE) alu_operation = ALU_OP_W'(BIT_OR);
        else if (funct3 == 3'b100 && funct7 == F7_BASE) alu_operation = ALU_OP_W'(BIT_XOR);
        else begin
          reg_write = 1'b0;
          illegal   = 1'b1;
        end
      end
      OP_I: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        case (funct3)
          3'b000:  alu_operation = ALU_OP_W'(ADD_64);
          3'b111:  alu_operation = ALU_OP_W'(BIT_AND);
          3'b110:  alu_operation = ALU_OP_W'(BIT_OR);
          3'b100:  alu_operation = ALU_OP_W'(BIT_XOR);
          default: begin
            reg_write = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        alu_src       = 1'b1;
        mem_to_reg    = 1'b1;
        reg_write     = 1'b1;
        mem_read      = 1'b1;
        alu_operation = ALU_OP_W'(ADD_64);
      end
      OP_STORE: begin
        alu_src       = 1'b1;
        mem_write     = 1'b1;
        alu_operation = ALU_OP_W'(ADD_64);
      end
      OP_BEQ: begin
        branch        = 1'b1;
        alu_operation = ALU_OP_W'(SUB_64);
      end
      OP_NOP:  ;
      default: is_halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipeline_ctl_unit.sv
// ID/EX pipeline control unit: decodes the ID instruction, registers the
// control bundle into EX, inserts bubbles on flush/hazard/invalid, and
// drains the pipeline after a HALT before asserting sticky halted.
// Ports: clk, reset (sync, active-high); id_valid, opcode, funct3, funct7,
//        hazard_detected, flush in; registered ex_valid, control bits,
//        alu_operation, illegal, halted, issue_count out.
module pipeline_ctl_unit
  import pipeline_ctl_unit_pkg::*;
#(
  parameter int ALU_OP_W     = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                hazard_detected,
  input  logic                flush,
  output logic                ex_valid,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic [ALU_OP_W-1:0] alu_operation,
  output logic                illegal,
  output logic                halted,
  output logic [CNT_W-1:0]    issue_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic                d_alu_src, d_mem_to_reg, d_reg_write;
  logic                d_mem_read, d_mem_write, d_branch;
  logic [ALU_OP_W-1:0] d_alu_operation;
  logic                d_is_halt, d_illegal;

  pipeline_ctl_decode #(.ALU_OP_W(ALU_OP_W)) u_decode (
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .alu_src       (d_alu_src),
    .mem_to_reg    (d_mem_to_reg),
    .reg_write     (d_reg_write),
    .mem_read      (d_mem_read),
    .mem_write     (d_mem_write),
    .branch        (d_branch),
    .alu_operation (d_alu_operation),
    .is_halt       (d_is_halt),
    .illegal       (d_illegal)
  );

  state_e              state, state_nxt;
  logic [DW-1:0]       drain_cnt, drain_cnt_nxt;
  logic                issue;

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    issue         = 1'b0;
    case (state)
      RUN: begin
        if (!flush && !hazard_detected && id_valid) begin
          if (d_is_halt) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DW'(DRAIN_CYCLES - 1);
          end else begin
            issue = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = HALTED;
        else                 drain_cnt_nxt = drain_cnt - 1'b1;
      end
      default: state_nxt = HALTED;
    endcase
  end

  // halted follows the state register by one edge, so it rises
  // DRAIN_CYCLES+1 edges after the HALT-accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      drain_cnt     <= '0;
      issue_count   <= '0;
      halted        <= 1'b0;
      ex_valid      <= 1'b0;
      alu_src       <= 1'b0;
      mem_to_reg    <= 1'b0;
      reg_write     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      branch        <= 1'b0;
      alu_operation <= ALU_OP_W'(ALU_NOP);
      illegal       <= 1'b0;
    end else begin
      state         <= state_nxt;
      drain_cnt     <= drain_cnt_nxt;
      halted        <= (state == HALTED);
      ex_valid      <= issue;
      alu_src       <= issue & d_alu_src;
      mem_to_reg    <= issue & d_mem_to_reg;
      reg_write     <= issue & d_reg_write;
      mem_read      <= issue & d_mem_read;
      mem_write     <= issue & d_mem_write;
      branch        <= issue & d_branch;
      alu_operation <= issue ? d_alu_operation : ALU_OP_W'(ALU_NOP);
      illegal       <= issue & d_illegal;
      if (issue && issue_count != '1) issue_count <= issue_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctl_unit.sv
module tb_pipeline_ctl_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic [6:0] funct7 = 7'b0;
  logic       hazard_detected = 1'b0;
  logic       flush = 1'b0;

  logic        ex_valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [2:0]  alu_operation;
  logic        illegal, halted;
  logic [15:0] issue_count;

  logic        s_ex_valid, s_alu_src, s_mem_to_reg, s_reg_write, s_mem_read, s_mem_write, s_branch;
  logic [2:0]  s_alu_operation;
  logic        s_illegal, s_halted;
  logic [3:0]  s_issue_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_ctl_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .hazard_detected(hazard_detected),
    .flush(flush), .ex_valid(ex_valid), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .alu_operation(alu_operation),
    .illegal(illegal), .halted(halted), .issue_count(issue_count)
  );

  pipeline_ctl_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .hazard_detected(hazard_detected),
    .flush(flush), .ex_valid(s_ex_valid), .alu_src(s_alu_src),
    .mem_to_reg(s_mem_to_reg), .reg_write(s_reg_write), .mem_read(s_mem_read),
    .mem_write(s_mem_write), .branch(s_branch), .alu_operation(s_alu_operation),
    .illegal(s_illegal), .halted(s_halted), .issue_count(s_issue_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7);
    id_valid = v;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 7'h00);
    step();
    step();
    total++;
    if ({ex_valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, illegal, halted} !== 9'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000000",
               {ex_valid, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, illegal, halted});
    end
    total++;
    if (alu_operation !== 3'd0 || issue_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_alu_cnt got alu=%0d cnt=%0d want alu=0 cnt=0", alu_operation, issue_count);
    end
    reset = 1'b0;
    drive(1'b0, 7'b0, 3'b0, 7'b0);
  endtask

  task automatic test_r_sub();
    drive(1'b1, 7'b0110011, 3'b000, 7'h20);
    step();
    total++;
    if (alu_operation !== 3'd2 || reg_write !== 1'b1 || ex_valid !== 1'b1 || alu_src !== 1'b0) begin
      bad++;
      $display("FAIL r_sub got alu=%0d rw=%b ev=%b as=%b want alu=2 rw=1 ev=1 as=0",
               alu_operation, reg_write, ex_valid, alu_src);
    end
    total++;
    if (issue_count !== 16'd1) begin
      bad++;
      $display("FAIL r_sub_cnt got=%0d want=1", issue_count);
    end
    drive(1'b0, 7'b0110011, 3'b000, 7'h20);
    step();
    total++;
    if (ex_valid !== 1'b0 || reg_write !== 1'b0 || alu_operation !== 3'd0 || issue_count !== 16'd1) begin
      bad++;
      $display("FAIL invalid_bubble got ev=%b rw=%b alu=%0d cnt=%0d want 0 0 0 1",
               ex_valid, reg_write, alu_operation, issue_count);
    end
  endtask

  task automatic test_load_hazard();
    drive(1'b1, 7'b0000011, 3'b011, 7'h00);
    step();
    total++;
    if ({alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} !== 6'b111100 ||
        alu_operation !== 3'd1 || ex_valid !== 1'b1 || issue_count !== 16'd2) begin
      bad++;
      $display("FAIL load got ctl=%b alu=%0d ev=%b cnt=%0d want ctl=111100 alu=1 ev=1 cnt=2",
               {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}, alu_operation, ex_valid, issue_count);
    end
    hazard_detected = 1'b1;
    step();
    total++;
    if (ex_valid !== 1'b0 || mem_read !== 1'b0 || mem_to_reg !== 1'b0 || issue_count !== 16'd2) begin
      bad++;
      $display("FAIL hazard_bubble got ev=%b mr=%b m2r=%b cnt=%0d want 0 0 0 2",
               ex_valid, mem_read, mem_to_reg, issue_count);
    end
    hazard_detected = 1'b0;
  endtask

  task automatic test_illegal();
    drive(1'b1, 7'b0110011, 3'b001, 7'h00);
    step();
    total++;
    if (illegal !== 1'b1 || reg_write !== 1'b0 || alu_operation !== 3'd0 || ex_valid !== 1'b1 || issue_count !== 16'd3) begin
      bad++;
      $display("FAIL illegal got il=%b rw=%b alu=%0d ev=%b cnt=%0d want 1 0 0 1 3",
               illegal, reg_write, alu_operation, ex_valid, issue_count);
    end
  endtask

  task automatic test_other_ops();
    // STORE
    drive(1'b1, 7'b0100011, 3'b010, 7'h00);
    step();
    total++;
    if ({alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} !== 6'b100010 || alu_operation !== 3'd1 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL store got ctl=%b alu=%0d il=%b want ctl=100010 alu=1 il=0",
               {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}, alu_operation, illegal);
    end
    // BEQ
    drive(1'b1, 7'b1100011, 3'b000, 7'h00);
    step();
    total++;
    if ({alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} !== 6'b000001 || alu_operation !== 3'd2) begin
      bad++;
      $display("FAIL beq got ctl=%b alu=%0d want ctl=000001 alu=2",
               {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}, alu_operation);
    end
    // NOP issues with ex_valid=1
    drive(1'b1, 7'b0000000, 3'b000, 7'h00);
    step();
    total++;
    if (ex_valid !== 1'b1 || {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} !== 6'b0 ||
        alu_operation !== 3'd0 || issue_count !== 16'd6) begin
      bad++;
      $display("FAIL nop got ev=%b ctl=%b alu=%0d cnt=%0d want ev=1 ctl=000000 alu=0 cnt=6",
               ex_valid, {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}, alu_operation, issue_count);
    end
    // R AND, I XOR, I OR
    drive(1'b1, 7'b0110011, 3'b111, 7'h00);
    step();
    total++;
    if (alu_operation !== 3'd3 || reg_write !== 1'b1 || alu_src !== 1'b0) begin
      bad++;
      $display("FAIL r_and got alu=%0d rw=%b as=%b want 3 1 0", alu_operation, reg_write, alu_src);
    end
    drive(1'b1, 7'b0010011, 3'b100, 7'h00);
    step();
    total++;
    if (alu_operation !== 3'd5 || reg_write !== 1'b1 || alu_src !== 1'b1 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL i_xor got alu=%0d rw=%b as=%b il=%b want 5 1 1 0", alu_operation, reg_write, alu_src, illegal);
    end
    total++;
    if (issue_count !== 16'd8) begin
      bad++;
      $display("FAIL count_after_ops got=%0d want=8", issue_count);
    end
  endtask

  task automatic test_halt();
    // HALT with hazard is not accepted; a following R must still issue.
    drive(1'b1, 7'b1111111, 3'b000, 7'h00);
    hazard_detected = 1'b1;
    step();
    hazard_detected = 1'b0;
    drive(1'b1, 7'b0110011, 3'b110, 7'h00);
    step();
    total++;
    if (ex_valid !== 1'b1 || alu_operation !== 3'd4 || issue_count !== 16'd9) begin
      bad++;
      $display("FAIL halt_hazard_ignored got ev=%b alu=%0d cnt=%0d want 1 4 9", ex_valid, alu_operation, issue_count);
    end
    // HALT with flush: bubble, stays in RUN.
    drive(1'b1, 7'b1111111, 3'b000, 7'h00);
    flush = 1'b1;
    step();
    total++;
    if (ex_valid !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_flush got ev=%b h=%b want 0 0", ex_valid, halted);
    end
    flush = 1'b0;
    step();  // HALT-accepting edge
    total++;
    if (ex_valid !== 1'b0 || issue_count !== 16'd9) begin
      bad++;
      $display("FAIL halt_accept_bubble got ev=%b cnt=%0d want 0 9", ex_valid, issue_count);
    end
    drive(1'b1, 7'b0110011, 3'b000, 7'h00);
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (halted !== 1'b0 || ex_valid !== 1'b0) begin
        bad++;
        $display("FAIL drain_edge%0d got h=%b ev=%b want 0 0", i, halted, ex_valid);
      end
    end
    step();
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL halted_edge4 got=%b want=1", halted);
    end
    step();
    step();
    total++;
    if (halted !== 1'b1 || ex_valid !== 1'b0 || issue_count !== 16'd9) begin
      bad++;
      $display("FAIL halted_sticky got h=%b ev=%b cnt=%0d want 1 0 9", halted, ex_valid, issue_count);
    end
  endtask

  task automatic test_reset_mid_drain();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 7'h00);
    step();
    drive(1'b1, 7'b1111111, 3'b000, 7'h00);
    step();  // accept -> first DRAIN cycle
    step();  // second DRAIN cycle
    reset = 1'b1;
    step();
    total++;
    if (halted !== 1'b0 || issue_count !== 16'd0 || ex_valid !== 1'b0 || alu_operation !== 3'd0) begin
      bad++;
      $display("FAIL reset_drain got h=%b cnt=%0d ev=%b alu=%0d want 0 0 0 0", halted, issue_count, ex_valid, alu_operation);
    end
    reset = 1'b0;
    drive(1'b1, 7'b0010011, 3'b110, 7'h00);
    step();
    total++;
    if (alu_operation !== 3'd4 || ex_valid !== 1'b1 || issue_count !== 16'd1) begin
      bad++;
      $display("FAIL post_reset_i_or got alu=%0d ev=%b cnt=%0d want 4 1 1", alu_operation, ex_valid, issue_count);
    end
    drive(1'b0, 7'b0, 3'b0, 7'b0);
    for (int i = 0; i < 5; i++) step();
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("FAIL no_stale_halt got=%b want=0", halted);
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 7'b0010011, 3'b000, 7'h00);
    for (int i = 0; i < 14; i++) step();
    total++;
    if (s_issue_count !== 4'd14) begin
      bad++;
      $display("FAIL sat_pre got=%0d want=14", s_issue_count);
    end
    for (int i = 0; i < 6; i++) step();
    total++;
    if (s_issue_count !== 4'd15 || issue_count !== 16'd20) begin
      bad++;
      $display("FAIL sat_hold got small=%0d big=%0d want 15 20", s_issue_count, issue_count);
    end
    drive(1'b0, 7'b0, 3'b0, 7'b0);
  endtask

  initial begin
    test_reset();
    test_r_sub();
    test_load_hazard();
    test_illegal();
    test_other_ops();
    test_halt();
    test_reset_mid_drain();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
